// File: rtl/display_scroll_controller.sv
// display_scroll_controller: phase counter, frame/scroll timing and tear-free
// character window over a 16-entry message buffer for a 4-digit display.
module display_scroll_controller #(
  parameter int PHASE_DIV  = 1000,
  parameter int SCROLL_DIV = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_en,
  input  logic [3:0] load_addr,
  input  logic [3:0] load_char,
  input  logic       run,
  input  logic       step_req,
  output logic [3:0] counter,
  output logic [3:0] c0,
  output logic [3:0] c1,
  output logic [3:0] c2,
  output logic [3:0] c3,
  output logic [3:0] ptr,
  output logic       frame_tick
);
  logic [15:0] presc_q, presc_d;
  logic [3:0]  counter_q, counter_d;
  logic [9:0]  fcnt_q, fcnt_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        step_q, tick_q;
  logic [3:0]  c0_q, c1_q, c2_q, c3_q;
  logic [3:0]  msg_q [16];
  logic        phase_tc, boundary, scroll_tc, step_edge;
  logic [3:0]  p1, p2, p3;
  always_comb begin
    phase_tc  = presc_q == 16'(PHASE_DIV - 1);
    boundary  = phase_tc && counter_q == 4'hf;
    scroll_tc = boundary && fcnt_q == 10'(SCROLL_DIV - 1);
    step_edge = step_req && !step_q && !run;
    presc_d   = phase_tc ? 16'd0 : presc_q + 16'd1;
    counter_d = phase_tc ? counter_q + 4'd1 : counter_q;
    fcnt_d    = scroll_tc ? 10'd0 : boundary ? fcnt_q + 10'd1 : fcnt_q;
    ptr_d     = ((scroll_tc && run) || step_edge) ? ptr_q + 4'd1 : ptr_q;
    p1        = ptr_q + 4'd1;
    p2        = ptr_q + 4'd2;
    p3        = ptr_q + 4'd3;
  end
  // The latch reads msg_q before this edge's write lands, so a coincident load shows a frame later.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      counter_q <= '0;
      fcnt_q    <= '0;
      ptr_q     <= '0;
      step_q    <= 1'b0;
      tick_q    <= 1'b0;
      c3_q      <= 4'h0;
      c2_q      <= 4'h1;
      c1_q      <= 4'h2;
      c0_q      <= 4'h3;
      for (int i = 0; i < 16; i++) msg_q[i] <= 4'(i);
    end else begin
      presc_q   <= presc_d;
      counter_q <= counter_d;
      fcnt_q    <= fcnt_d;
      ptr_q     <= ptr_d;
      step_q    <= step_req;
      tick_q    <= boundary;
      if (boundary) begin
        c3_q <= msg_q[ptr_q];
        c2_q <= msg_q[p1];
        c1_q <= msg_q[p2];
        c0_q <= msg_q[p3];
      end
      if (load_en) msg_q[load_addr] <= load_char;
    end
  end
  assign counter    = counter_q;
  assign ptr        = ptr_q;
  assign frame_tick = tick_q;
  assign c0         = c0_q;
  assign c1         = c1_q;
  assign c2         = c2_q;
  assign c3         = c3_q;
endmodule

// File: tb/tb_display_scroll_controller.sv
// tb_display_scroll_controller: directed checks of phase, frame, scroll, step,
// load and reset behaviour with PHASE_DIV=2, SCROLL_DIV=2 (32 cycles per frame).
module tb_display_scroll_controller;
  logic       clk = 1'b0;
  logic       reset, load_en, run, step_req, frame_tick;
  logic [3:0] load_addr, load_char, counter, c0, c1, c2, c3, ptr;
  logic [15:0] chars;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign chars = {c3, c2, c1, c0};

  display_scroll_controller #(.PHASE_DIV(2), .SCROLL_DIV(2)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_char(load_char), .run(run), .step_req(step_req), .counter(counter),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .ptr(ptr), .frame_tick(frame_tick)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; load_en = 1'b0; run = 1'b0; step_req = 1'b0;
    load_addr = 4'h0; load_char = 4'h0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!frame_tick && n < 40);
    checks++;
    if (frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL %s frame_tick timeout got=%b want=1", name, frame_tick);
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks += 4;
    if (counter !== 4'h0) begin failures++; $display("FAIL reset_counter got=%h want=0", counter); end
    if (ptr !== 4'h0) begin failures++; $display("FAIL reset_ptr got=%h want=0", ptr); end
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b want=0", frame_tick); end
    if (chars !== 16'h0123) begin failures++; $display("FAIL reset_chars got=%h want=0123", chars); end
  endtask

  task automatic test_phase;
    logic [3:0] exp_cnt;
    do_reset();
    for (int k = 1; k <= 33; k++) begin
      tick();
      exp_cnt = 4'((k / 2) % 16);
      checks += 2;
      if (counter !== exp_cnt) begin failures++; $display("FAIL phase_counter k=%0d got=%h want=%h", k, counter, exp_cnt); end
      if (frame_tick !== (k == 32)) begin failures++; $display("FAIL phase_tick k=%0d got=%b want=%b", k, frame_tick, k == 32); end
    end
    checks++;
    if (chars !== 16'h0123) begin failures++; $display("FAIL phase_chars got=%h want=0123", chars); end
  endtask

  task automatic test_autoscroll;
    do_reset();
    run = 1'b1;
    wait_frame("auto_f1");
    checks += 2;
    if (ptr !== 4'h0) begin failures++; $display("FAIL auto_f1_ptr got=%h want=0", ptr); end
    if (chars !== 16'h0123) begin failures++; $display("FAIL auto_f1_chars got=%h want=0123", chars); end
    wait_frame("auto_f2");
    checks += 2;
    if (ptr !== 4'h1) begin failures++; $display("FAIL auto_f2_ptr got=%h want=1", ptr); end
    if (chars !== 16'h0123) begin failures++; $display("FAIL auto_f2_chars got=%h want=0123", chars); end
    wait_frame("auto_f3");
    checks += 2;
    if (ptr !== 4'h1) begin failures++; $display("FAIL auto_f3_ptr got=%h want=1", ptr); end
    if (chars !== 16'h1234) begin failures++; $display("FAIL auto_f3_chars got=%h want=1234", chars); end
    repeat (28) wait_frame("auto_run");
    checks++;
    if (ptr !== 4'hf) begin failures++; $display("FAIL auto_f31_ptr got=%h want=f", ptr); end
    wait_frame("auto_f32");
    checks += 2;
    if (ptr !== 4'h0) begin failures++; $display("FAIL auto_f32_ptr got=%h want=0", ptr); end
    if (chars !== 16'hf012) begin failures++; $display("FAIL auto_f32_chars got=%h want=f012", chars); end
    run = 1'b0;
  endtask

  task automatic test_wrap;
    do_reset();
    repeat (13) begin
      step_req = 1'b1; tick();
      step_req = 1'b0; tick();
    end
    checks += 2;
    if (ptr !== 4'hd) begin failures++; $display("FAIL wrap_ptr got=%h want=d", ptr); end
    if (chars !== 16'h0123) begin failures++; $display("FAIL wrap_prelatch got=%h want=0123", chars); end
    wait_frame("wrap_frame");
    checks++;
    if (chars !== 16'hdef0) begin failures++; $display("FAIL wrap_chars got=%h want=def0", chars); end
  endtask

  task automatic test_load;
    do_reset();
    step_req = 1'b1; tick();
    step_req = 1'b0; tick();
    wait_frame("load_f1");
    checks++;
    if (chars !== 16'h1234) begin failures++; $display("FAIL load_f1_chars got=%h want=1234", chars); end
    repeat (5) tick();
    load_en = 1'b1; load_addr = 4'h4; load_char = 4'ha;
    tick();
    load_en = 1'b0;
    tick();
    checks++;
    if (c0 !== 4'h4) begin failures++; $display("FAIL load_midframe_c0 got=%h want=4", c0); end
    wait_frame("load_f2");
    checks++;
    if (c0 !== 4'ha) begin failures++; $display("FAIL load_f2_c0 got=%h want=a", c0); end
    repeat (31) tick();
    load_en = 1'b1; load_addr = 4'h4; load_char = 4'hc;
    tick();
    load_en = 1'b0;
    checks += 2;
    if (frame_tick !== 1'b1) begin failures++; $display("FAIL load_coincident_tick got=%b want=1", frame_tick); end
    if (c0 !== 4'ha) begin failures++; $display("FAIL load_coincident_c0 got=%h want=a", c0); end
    wait_frame("load_f4");
    checks++;
    if (c0 !== 4'hc) begin failures++; $display("FAIL load_after_c0 got=%h want=c", c0); end
  endtask

  task automatic test_step_hold;
    do_reset();
    step_req = 1'b1;
    repeat (40) tick();
    checks++;
    if (ptr !== 4'h1) begin failures++; $display("FAIL hold_ptr got=%h want=1", ptr); end
    step_req = 1'b0;
    tick();
    run = 1'b1; step_req = 1'b1;
    repeat (5) tick();
    checks++;
    if (ptr !== 4'h1) begin failures++; $display("FAIL run_step_ptr got=%h want=1", ptr); end
    step_req = 1'b0; run = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    repeat (3) begin
      step_req = 1'b1; tick();
      step_req = 1'b0; tick();
    end
    repeat (4) wait_frame("mid_frames");
    load_en = 1'b1; load_addr = 4'h4; load_char = 4'h9;
    tick();
    load_en = 1'b0;
    repeat (3) tick();
    checks += 3;
    if (ptr !== 4'h3) begin failures++; $display("FAIL mid_ptr got=%h want=3", ptr); end
    if (chars !== 16'h3456) begin failures++; $display("FAIL mid_chars got=%h want=3456", chars); end
    if (counter !== 4'h2) begin failures++; $display("FAIL mid_counter got=%h want=2", counter); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks += 4;
    if (counter !== 4'h0) begin failures++; $display("FAIL rst_mid_counter got=%h want=0", counter); end
    if (ptr !== 4'h0) begin failures++; $display("FAIL rst_mid_ptr got=%h want=0", ptr); end
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL rst_mid_tick got=%b want=0", frame_tick); end
    if (chars !== 16'h0123) begin failures++; $display("FAIL rst_mid_chars got=%h want=0123", chars); end
    step_req = 1'b1; tick();
    step_req = 1'b0;
    wait_frame("rst_msg_frame");
    checks++;
    if (chars !== 16'h1234) begin failures++; $display("FAIL rst_msg_chars got=%h want=1234", chars); end
  endtask

  initial begin
    test_reset();
    test_phase();
    test_autoscroll();
    test_wrap();
    test_load();
    test_step_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
